// File: rtl/bus_responder.sv
// bus_responder: target side of the CPU native bus. Decodes an aligned
// window of 2**REG_CNT_LG2 words, holds a word-wide register bank, and
// acknowledges each request after WAIT_STATES idle cycles.
// Optional build macro: BUS_RESPONDER_TIMER_EN turns the last register into
// a free-running read-only cycle counter.
module bus_responder #(
   parameter int              DATA_W      = 32,
   parameter int              ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'hFFFF0000,
   parameter int              REG_CNT_LG2 = 4,
   parameter int              WAIT_STATES = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_bus_clk,
   input  logic              i_bus_we,
   input  logic [ADDR_W-1:0] i_bus_addr,
   input  logic [DATA_W-1:0] i_bus_data,
   output logic [DATA_W-1:0] o_bus_data,
   output logic              o_bus_data_ready,
   output logic              o_sel
);

   localparam int NREG = 1 << REG_CNT_LG2;
   localparam int IW   = REG_CNT_LG2;
   localparam logic [IW-1:0] LAST_IDX = IW'(NREG - 1);

   typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;

   state_t            state, state_nxt;
   logic [3:0]        cnt;
   logic              lat_we;
   logic [IW-1:0]     lat_idx;
   logic [DATA_W-1:0] lat_wdata;
   logic [DATA_W-1:0] regs [NREG];
   logic [DATA_W-1:0] rd_val;
   logic              hit;
   logic              unused_addr_lsb;

   // byte lane bits carry no meaning on a word-only bus
   assign unused_addr_lsb = &{1'b0, i_bus_addr[1:0]};

   assign hit = i_bus_clk &&
                (i_bus_addr[ADDR_W-1:IW+2] == BASE_ADDR[ADDR_W-1:IW+2]);

   // state register
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   // next-state: a dropped strobe while waiting aborts the request
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (hit) state_nxt = (WAIT_STATES == 0) ? ACK : WAIT;
         WAIT: begin
            if (!i_bus_clk)    state_nxt = IDLE;
            else if (cnt == 1) state_nxt = ACK;
         end
         ACK:  state_nxt = HOLD;
         HOLD: if (!i_bus_clk) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // request capture and wait-state countdown
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt       <= '0;
         lat_we    <= 1'b0;
         lat_idx   <= '0;
         lat_wdata <= '0;
      end else begin
         case (state)
            IDLE: if (hit) begin
               cnt       <= 4'(WAIT_STATES);
               lat_we    <= i_bus_we;
               lat_idx   <= i_bus_addr[IW+1:2];
               lat_wdata <= i_bus_data;
            end
            WAIT: cnt <= i_bus_clk ? cnt - 4'd1 : 4'd0;
            default: cnt <= cnt;
         endcase
      end
   end

`ifdef BUS_RESPONDER_TIMER_EN
   logic [DATA_W-1:0] timer;

   // free-running cycle counter, wraps naturally at all-ones
   always_ff @(posedge i_clk) begin
      if (i_rst) timer <= '0;
      else       timer <= timer + 1'b1;
   end

   // register bank; the timer slot swallows writes
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (state == ACK && lat_we && lat_idx != LAST_IDX) begin
         regs[lat_idx] <= lat_wdata;
      end
   end

   // read source, timer value is the one present in the ack cycle
   always_comb begin
      rd_val = regs[lat_idx];
      if (lat_idx == LAST_IDX) rd_val = timer;
   end
`else
   logic unused_last;
   assign unused_last = &{1'b0, LAST_IDX};

   // register bank, writes commit in the ack cycle
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (state == ACK && lat_we) begin
         regs[lat_idx] <= lat_wdata;
      end
   end

   // read source
   always_comb begin
      rd_val = regs[lat_idx];
   end
`endif

   // outputs: data bus is zero outside a read ack so responders can be OR-ed
   always_comb begin
      o_bus_data_ready = (state == ACK);
      o_sel            = (state == WAIT) || (state == ACK);
      o_bus_data       = '0;
      if (state == ACK && !lat_we) o_bus_data = rd_val;
   end

endmodule

// File: tb/tb_bus_responder.sv
// Scoreboard bench for bus_responder: stimulus pushes expected responses,
// a negedge monitor pops and checks them whenever ready is seen.
// Honours BUS_RESPONDER_TIMER_EN for the timer-register scenarios.
module tb_bus_responder;

   localparam logic [31:0] BASE = 32'hFFFF0000;
   localparam int          W    = 2;

   logic        clk = 0;
   logic        rst = 1;
   logic        b_clk = 0, b_we = 0;
   logic [31:0] b_addr = 0, b_data = 0;
   logic [31:0] r_data;
   logic        r_rdy, r_sel;

   bus_responder #(.DATA_W(32), .ADDR_W(32), .BASE_ADDR(BASE),
                   .REG_CNT_LG2(4), .WAIT_STATES(W)) dut (
      .i_clk(clk), .i_rst(rst), .i_bus_clk(b_clk), .i_bus_we(b_we),
      .i_bus_addr(b_addr), .i_bus_data(b_data),
      .o_bus_data(r_data), .o_bus_data_ready(r_rdy), .o_sel(r_sel));

   always #5 clk = ~clk;

   typedef struct {
      bit          rd;
      bit          tmr;
      logic [31:0] data;
      int          cap;
   } exp_t;

   exp_t        q[$];
   logic [31:0] model [16];
   int          tests = 0, fails = 0;
   int          edges = 0, acks = 0, sel_cnt = 0;
   logic [31:0] cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // edge counter and cycles-since-reset reference for the timer
   always @(posedge clk) begin
      edges <= edges + 1;
      cyc   <= rst ? 32'd0 : cyc + 32'd1;
   end

   // monitor: every ready pulse must match the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (r_sel) sel_cnt++;
      if (r_rdy) begin
         acks++;
         if (q.size() == 0) begin
            chk("unexpected_ready", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            chk("latency", 32'(edges - e.cap + 1), 32'(W + 1));
            if (e.rd) chk(e.tmr ? "timer_read" : "read_data", r_data, e.tmr ? cyc : e.data);
            else      chk("write_ack_data", r_data, 32'd0);
         end
      end else if (r_data !== 32'd0) begin
         chk("data_idle_zero", r_data, 32'd0);
      end
   end

   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1;
      repeat (n) @(negedge clk);
      chk("rst_ready", 32'(r_rdy), 32'd0);
      chk("rst_data", r_data, 32'd0);
      chk("rst_sel", 32'(r_sel), 32'd0);
      rst = 0; b_clk = 0;
      q.delete();
      for (int i = 0; i < 16; i++) model[i] = 32'd0;
   endtask

   task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                      input int hold, input bit scr);
      exp_t e;
      int   a0, s0, idx;
      bit   hit;
      idx = int'(addr[5:2]);
      hit = (addr[31:6] == BASE[31:6]);
      @(negedge clk);
      a0 = acks; s0 = sel_cnt;
      b_clk = 1; b_we = we; b_addr = addr; b_data = wd;
      if (hit) begin
         e.rd = !we; e.tmr = 0;
`ifdef BUS_RESPONDER_TIMER_EN
         e.tmr = (idx == 15);
`endif
         e.data = we ? 32'd0 : model[idx];
         e.cap  = edges + 1;
         q.push_back(e);
         if (we && !e.tmr) model[idx] = wd;
         @(posedge clk); #1;
         chk("sel_in_wait", 32'(r_sel), 32'd1);
         for (int k = 0; k < 40 && acks == a0; k++) begin
            if (scr) begin b_addr = $urandom; b_data = $urandom; end
            @(posedge clk);
         end
         chk("ack_seen", 32'(acks - a0), 32'd1);
         repeat (hold) @(posedge clk);
         @(negedge clk);
         chk("single_ack", 32'(acks - a0), 32'd1);
         b_clk = 0;
      end else begin
         repeat (hold + 1) @(negedge clk);
         chk("miss_no_ack", 32'(acks - a0), 32'd0);
         chk("miss_no_sel", 32'(sel_cnt - s0), 32'd0);
         b_clk = 0;
      end
   endtask

   task automatic txn_abort(input logic [31:0] addr, input logic [31:0] wd);
      int a0;
      @(negedge clk);
      a0 = acks;
      b_clk = 1; b_we = 1; b_addr = addr; b_data = wd;
      @(negedge clk);
      chk("abort_sel_hi", 32'(r_sel), 32'd1);
      b_clk = 0;
      repeat (5) @(negedge clk);
      chk("abort_no_ack", 32'(acks - a0), 32'd0);
      chk("abort_sel_lo", 32'(r_sel), 32'd0);
   endtask

   // watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      for (int i = 0; i < 16; i++) model[i] = 32'd0;

      // reset and first read
      do_reset(2);
      txn(0, BASE + 32'h0C, 32'd0, 0, 0);

      // write then readback with wait states
      txn(1, BASE + 32'h0C, 32'hDEADBEEF, 0, 0);
      txn(0, BASE + 32'h0C, 32'd0, 0, 0);

      // miss held 20 cycles
      txn(0, 32'h00001000, 32'd0, 19, 0);
      txn(1, 32'h00001000, 32'h55AA55AA, 19, 0);

      // aborted write leaves the register untouched
      txn_abort(BASE + 32'h04, 32'h12345678);
      txn(0, BASE + 32'h04, 32'd0, 0, 0);

      // long strobe after ack, then back-to-back
      txn(1, BASE + 32'h08, 32'hCAFEF00D, 10, 0);
      txn(0, BASE + 32'h08, 32'd0, 10, 0);

      // request fields changed during wait are ignored
      txn(1, BASE + 32'h10, 32'hA5A5A5A5, 1, 1);
      txn(0, BASE + 32'h10, 32'd0, 0, 1);

      // randomized traffic, including byte-offset bits and misses
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 7) == 0) a = {$urandom_range(0, 32'hFFFE) & 32'hFFFF, 16'h0} ^ 32'h0000_1000;
         else a = BASE | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
         if (a[31:6] == BASE[31:6] && a[31:16] != 16'hFFFF) a = 32'h00002000;
         txn($urandom_range(0, 1) == 1, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 1) == 1);
      end

      // reset in the middle of a write
      @(negedge clk);
      b_clk = 1; b_we = 1; b_addr = BASE + 32'h14; b_data = 32'h0BADF00D;
      @(negedge clk);
      do_reset(1);
      txn(0, BASE + 32'h14, 32'd0, 0, 0);
      txn(0, BASE + 32'h0C, 32'd0, 0, 0);

`ifdef BUS_RESPONDER_TIMER_EN
      // timer reads, ignored write, wrap
      txn(0, BASE + 32'h3C, 32'd0, 0, 0);
      repeat (6) @(negedge clk);
      txn(0, BASE + 32'h3C, 32'd0, 0, 0);
      txn(1, BASE + 32'h3C, 32'd0, 0, 0);
      txn(0, BASE + 32'h3C, 32'd0, 0, 0);
      @(negedge clk);
      force dut.timer = 32'hFFFFFFFF;
      @(negedge clk);
      release dut.timer;
      @(posedge clk); #1;
      chk("timer_wrap", dut.timer, 32'd0);
`else
      // last index behaves as a plain register
      txn(1, BASE + 32'h3C, 32'h600DCAFE, 0, 0);
      txn(0, BASE + 32'h3C, 32'd0, 0, 0);
`endif

      repeat (4) @(negedge clk);
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
